fwd_hazard_unit: RTL and testbench

Parametrised successor to the pipeline forwarding unit for the RV32I core. It combines three functions:
- Per-operand EX-stage forwarding selects, covering any number of source operands.
- A per-register scoreboard of countdown counters that stalls ID on multi-cycle producers (loads, multi-cycle ALU ops).
- A sticky error flag and a saturating stall-cycle counter.

It sits between ID/EX control and the operand muxes in EX, and drives the ID/IF stall enables.

---
 rtl/fwd_pkg.sv | 12 +
 rtl/hazard_scoreboard.sv | 49 ++++
 rtl/fwd_hazard_unit.sv | 105 ++++++++++
 tb/tb_fwd_hazard_unit.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
// Shared encodings for the forwarding/hazard unit.
// Operand select codes and producer latency classes.
package fwd_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam int LAT_ALU  = 0;
  localparam int LAT_LOAD = 1;

endpackage

// File: rtl/hazard_scoreboard.sv
// Per-register countdown scoreboard.
// Tracks cycles until each pending result can be forwarded.
module hazard_scoreboard #(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int NSRC = 2,
  parameter int LW   = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_idx,
  input  logic [LW-1:0]   wr_lat,
  input  logic [AW-1:0]   rd_idx [NSRC],
  output logic [NSRC-1:0] rd_busy,
  output logic [NREG-1:0] busy_out
);

  logic [LW-1:0] cnt_q [NREG];
  logic [LW-1:0] cnt_d [NREG];

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - LW'(1) : '0;
      if (wr_en && (wr_idx == AW'(r)))
        cnt_d[r] = wr_lat;
    end
    // x0 never holds a pending value
    cnt_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    for (int r = 0; r < NREG; r++) begin
      if (!rst_n) cnt_q[r] <= '0;
      else        cnt_q[r] <= cnt_d[r];
    end
  end

  always_comb begin
    for (int r = 0; r < NREG; r++)
      busy_out[r] = (cnt_q[r] != '0);
  end

  always_comb begin
    for (int k = 0; k < NSRC; k++)
      rd_busy[k] = busy_out[rd_idx[k]];
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// EX operand forwarding, ID load-use stall and hazard statistics.
// Sits between ID/EX control and the EX operand muxes.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int NSRC = 2,
  parameter int LW   = 3,
  parameter int SCW  = 16
) (
  input  logic                 ip_clk,
  input  logic                 ip_rst_n,
  input  logic                 ip_id_valid,
  input  logic [NSRC*AW-1:0]   ip_id_rs,
  input  logic [AW-1:0]        ip_id_rd,
  input  logic                 ip_id_regwrite,
  input  logic [LW-1:0]        ip_id_lat,
  input  logic                 ip_flush,
  input  logic [NSRC*AW-1:0]   ip_ex_rs,
  input  logic [AW-1:0]        ip_exmem_rd,
  input  logic                 ip_exmem_regwrite,
  input  logic                 ip_exmem_fwd_ok,
  input  logic [AW-1:0]        ip_memwb_rd,
  input  logic                 ip_memwb_regwrite,
  output logic                 op_stall,
  output logic [NSRC*2-1:0]    op_fwd_sel,
  output logic [NREG-1:0]      op_busy,
  output logic                 op_err,
  output logic [SCW-1:0]       op_stall_cnt
);

  logic [AW-1:0]   id_rs [NSRC];
  logic [AW-1:0]   ex_rs [NSRC];
  logic [NSRC-1:0] src_busy;
  logic [NSRC-1:0] viol;
  logic            issue;
  logic            err_q, err_d;
  logic [SCW-1:0]  stall_q, stall_d;

  always_comb begin
    for (int k = 0; k < NSRC; k++) begin
      id_rs[k] = ip_id_rs[k*AW +: AW];
      ex_rs[k] = ip_ex_rs[k*AW +: AW];
    end
  end

  hazard_scoreboard #(
    .NREG (NREG),
    .AW   (AW),
    .NSRC (NSRC),
    .LW   (LW)
  ) u_sb (
    .clk      (ip_clk),
    .rst_n    (ip_rst_n),
    .wr_en    (issue),
    .wr_idx   (ip_id_rd),
    .wr_lat   (ip_id_lat),
    .rd_idx   (id_rs),
    .rd_busy  (src_busy),
    .busy_out (op_busy)
  );

  assign op_stall = ip_id_valid & ~ip_flush & (|src_busy);
  assign issue    = ip_id_valid & ~op_stall & ~ip_flush
                  & ip_id_regwrite & (ip_id_rd != '0);

  always_comb begin
    op_fwd_sel = '0;
    viol       = '0;
    for (int k = 0; k < NSRC; k++) begin
      logic mem_hit;
      logic wb_hit;
      mem_hit = ip_exmem_regwrite && (ip_exmem_rd != '0)
             && (ip_exmem_rd == ex_rs[k]);
      wb_hit  = ip_memwb_regwrite && (ip_memwb_rd != '0)
             && (ip_memwb_rd == ex_rs[k]);
      // a not-yet-ready EX/MEM producer shadows any older MEM/WB copy
      unique case (1'b1)
        mem_hit &&  ip_exmem_fwd_ok: op_fwd_sel[2*k +: 2] = FWD_MEM;
        mem_hit && !ip_exmem_fwd_ok: viol[k] = 1'b1;
        !mem_hit && wb_hit:          op_fwd_sel[2*k +: 2] = FWD_WB;
        default: ;
      endcase
    end
  end

  assign err_d   = err_q | (|viol);
  assign stall_d = (op_stall && (stall_q != '1))
                 ? stall_q + SCW'(1) : stall_q;

  always_ff @(posedge ip_clk) begin
    if (!ip_rst_n) begin
      err_q   <= 1'b0;
      stall_q <= '0;
    end else begin
      err_q   <= err_d;
      stall_q <= stall_d;
    end
  end

  assign op_err       = err_q;
  assign op_stall_cnt = stall_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit.
// A second instance with wide latency and narrow counter covers saturation.
module tb_fwd_hazard_unit;

  logic        ip_clk;
  logic        rst_n, id_valid, id_we, flush;
  logic        xw, xok, ww;
  logic [9:0]  id_rs, ex_rs;
  logic [4:0]  id_rd, xr, wr, lat5;
  logic        stall, s_stall, err, s_err;
  logic [3:0]  sel, s_sel;
  logic [31:0] busy, s_busy;
  logic [15:0] scnt;
  logic [3:0]  s_scnt;

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    logic [4:0] rs0;
    logic [4:0] rs1;
    logic [4:0] xr;
    logic       xw;
    logic       xok;
    logic [4:0] wr;
    logic       ww;
    logic [3:0] sel;
  } fvec_t;

  fvec_t tbl [8];

  fwd_hazard_unit #(.NREG(32), .AW(5), .NSRC(2), .LW(3), .SCW(16)) dut (
    .ip_clk            (ip_clk),
    .ip_rst_n          (rst_n),
    .ip_id_valid       (id_valid),
    .ip_id_rs          (id_rs),
    .ip_id_rd          (id_rd),
    .ip_id_regwrite    (id_we),
    .ip_id_lat         (lat5[2:0]),
    .ip_flush          (flush),
    .ip_ex_rs          (ex_rs),
    .ip_exmem_rd       (xr),
    .ip_exmem_regwrite (xw),
    .ip_exmem_fwd_ok   (xok),
    .ip_memwb_rd       (wr),
    .ip_memwb_regwrite (ww),
    .op_stall          (stall),
    .op_fwd_sel        (sel),
    .op_busy           (busy),
    .op_err            (err),
    .op_stall_cnt      (scnt)
  );

  fwd_hazard_unit #(.NREG(32), .AW(5), .NSRC(2), .LW(5), .SCW(4)) u_sat (
    .ip_clk            (ip_clk),
    .ip_rst_n          (rst_n),
    .ip_id_valid       (id_valid),
    .ip_id_rs          (id_rs),
    .ip_id_rd          (id_rd),
    .ip_id_regwrite    (id_we),
    .ip_id_lat         (lat5),
    .ip_flush          (flush),
    .ip_ex_rs          (ex_rs),
    .ip_exmem_rd       (xr),
    .ip_exmem_regwrite (xw),
    .ip_exmem_fwd_ok   (xok),
    .ip_memwb_rd       (wr),
    .ip_memwb_regwrite (ww),
    .op_stall          (s_stall),
    .op_fwd_sel        (s_sel),
    .op_busy           (s_busy),
    .op_err            (s_err),
    .op_stall_cnt      (s_scnt)
  );

  initial ip_clk = 1'b0;
  always #5 ip_clk = ~ip_clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge ip_clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_rs = '0; id_rd = '0; id_we = 0;
    lat5 = '0; flush = 0; ex_rs = '0;
    xr = '0; xw = 0; xok = 0; wr = '0; ww = 0;
  endtask

  task automatic id_issue(input logic [4:0] rd, input logic [4:0] l,
                          input logic [4:0] r0, input logic [4:0] r1);
    id_valid = 1; id_we = 1; id_rd = rd; lat5 = l;
    id_rs = {r1, r0};
  endtask

  initial begin
    int n;
    tbl[0] = '{5'd0,  5'd3,  5'd3,  1, 1, 5'd3,  1, 4'b1000};
    tbl[1] = '{5'd0,  5'd0,  5'd0,  1, 1, 5'd0,  1, 4'b0000};
    tbl[2] = '{5'd2,  5'd9,  5'd9,  1, 1, 5'd2,  1, 4'b1001};
    tbl[3] = '{5'd4,  5'd4,  5'd4,  0, 1, 5'd4,  1, 4'b0101};
    tbl[4] = '{5'd6,  5'd7,  5'd6,  1, 1, 5'd7,  0, 4'b0010};
    tbl[5] = '{5'd31, 5'd30, 5'd30, 1, 1, 5'd31, 1, 4'b1001};
    tbl[6] = '{5'd1,  5'd1,  5'd2,  1, 1, 5'd3,  1, 4'b0000};
    tbl[7] = '{5'd5,  5'd0,  5'd0,  1, 1, 5'd5,  1, 4'b0001};

    idle();
    rst_n = 0;
    id_issue(5'd5, 5'd3, 5'd0, 5'd0);
    xr = 5'd3; xw = 1; xok = 1; ex_rs = {5'd0, 5'd3};
    step();
    chk("rst_fwd_tracks", 32'(sel[1:0]), 32'h2);
    step();
    rst_n = 1;
    idle();
    #1;
    chk("rst_stall", 32'(stall), 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_scnt", 32'(scnt), 0);
    step();
    chk("rst_no_issue", busy, 0);

    // ALU back-to-back
    id_issue(5'd5, 5'd0, 5'd0, 5'd0);
    #1;
    chk("alu_p_stall", 32'(stall), 0);
    step();
    id_issue(5'd6, 5'd0, 5'd5, 5'd1);
    xr = 5'd5; xw = 1; xok = 1; ex_rs = {5'd1, 5'd5};
    #1;
    chk("alu_c_stall", 32'(stall), 0);
    chk("alu_fwd", 32'(sel), 32'h2);
    step();
    idle();

    // Load-use
    id_issue(5'd7, 5'd1, 5'd0, 5'd0);
    #1;
    chk("lu_p_stall", 32'(stall), 0);
    step();
    id_issue(5'd8, 5'd0, 5'd7, 5'd7);
    #1;
    chk("lu_stall", 32'(stall), 1);
    chk("lu_busy7", 32'(busy[7]), 1);
    step();
    chk("lu_release", 32'(stall), 0);
    wr = 5'd7; ww = 1; ex_rs = {5'd7, 5'd7};
    #1;
    chk("lu_fwd_wb", 32'(sel), 32'h5);
    chk("lu_scnt", 32'(scnt), 1);
    step();
    idle();

    // Flush and lat 3
    id_issue(5'd9, 5'd3, 5'd0, 5'd0);
    step();
    id_issue(5'd10, 5'd2, 5'd9, 5'd0);
    flush = 1;
    #1;
    chk("fl_stall", 32'(stall), 0);
    chk("fl_busy9", 32'(busy[9]), 1);
    step();
    chk("fl_no_issue", 32'(busy[10]), 0);
    flush = 0;
    #1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (!stall) break;
      n++;
      step();
    end
    chk("fl_stall_len", 32'(n), 2);
    chk("fl_busy9_fall", 32'(busy[9]), 0);
    step();
    chk("fl_issue10", 32'(busy[10]), 1);
    chk("fl_scnt", 32'(scnt), 3);
    idle();
    step();

    // Saturation on the narrow-counter instance
    id_issue(5'd12, 5'd20, 5'd0, 5'd0);
    step();
    idle();
    id_valid = 1; id_rs = {5'd0, 5'd12};
    #1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (!s_stall) break;
      n++;
      step();
    end
    chk("sat_stall_len", 32'(n), 20);
    chk("sat_scnt", 32'(s_scnt), 15);
    chk("main_scnt", 32'(scnt), 7);
    idle();
    step();

    // Violation
    xr = 5'd4; xw = 1; xok = 0; wr = 5'd4; ww = 1;
    ex_rs = {5'd0, 5'd4};
    #1;
    chk("viol_sel", 32'(sel), 0);
    chk("viol_err_pre", 32'(err), 0);
    step();
    chk("viol_err", 32'(err), 1);
    idle();
    step(); step(); step();
    chk("viol_sticky", 32'(err), 1);

    foreach (tbl[i]) begin
      ex_rs = {tbl[i].rs1, tbl[i].rs0};
      xr = tbl[i].xr; xw = tbl[i].xw; xok = tbl[i].xok;
      wr = tbl[i].wr; ww = tbl[i].ww;
      #1;
      chk($sformatf("tbl%0d_sel", i), 32'(sel), 32'(tbl[i].sel));
      step();
    end
    idle();

    // Reset discards pending entries
    id_issue(5'd13, 5'd3, 5'd0, 5'd0);
    step();
    chk("pend_busy13", 32'(busy[13]), 1);
    idle();
    rst_n = 0;
    step();
    rst_n = 1;
    #1;
    chk("rst2_busy", busy, 0);
    chk("rst2_err", 32'(err), 0);
    chk("rst2_scnt", 32'(scnt), 0);
    chk("rst2_s_scnt", 32'(s_scnt), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
